// File: rtl/anton_neopixel_sequencer_if.sv
// Control and status bundle between the register block and the NeoPixel
// sequencer. The register side drives the control fields. The sequencer
// drives the timing/index status consumed by the bit encoder.
interface anton_neopixel_sequencer_if #(
    parameter int BUFFER_BITS = 8
);
    logic                   regCtrlRun;
    logic                   regCtrlLoop;
    logic                   regCtrl32bit;
    logic [BUFFER_BITS-1:0] regLastPixel;

    logic                   state;
    logic [2:0]             bitPatternIndex;
    logic [2:0]             pixelBitIndex;
    logic [1:0]             channelIndex;
    logic [BUFFER_BITS-1:0] bufferAddr;
    logic                   frameDone;
    logic                   busy;

    modport master (
        output regCtrlRun, regCtrlLoop, regCtrl32bit, regLastPixel,
        input  state, bitPatternIndex, pixelBitIndex, channelIndex,
               bufferAddr, frameDone, busy
    );

    modport slave (
        input  regCtrlRun, regCtrlLoop, regCtrl32bit, regLastPixel,
        output state, bitPatternIndex, pixelBitIndex, channelIndex,
               bufferAddr, frameDone, busy
    );
endinterface

// File: rtl/anton_neopixel_sequencer.sv
// NeoPixel frame sequencer: walks slot/bit/channel/pixel counters over the
// pixel buffer, then holds the line low for a reset gap between frames.
// Frame settings (last pixel, byte mode) are captured at each frame start.
// All outputs are registered.

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef ENUM_STATE_TRANSMIT
`define ENUM_STATE_TRANSMIT 1'b1
`endif
`ifndef ENUM_STATE_RESET
`define ENUM_STATE_RESET 1'b0
`endif

module anton_neopixel_sequencer #(
    parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
    parameter int RESET_CYCLES = 400,
    localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
    input logic                     clk6_4mhz,
    input logic                     rstn,
    anton_neopixel_sequencer_if.slave bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] TRANSMIT = 2'd1;
    localparam logic [1:0] GAP      = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam int GAP_BITS = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [GAP_BITS-1:0]    GAP_LAST  = GAP_BITS'(RESET_CYCLES - 1);
    localparam logic [BUFFER_BITS-1:0] MAX_PIX8  = BUFFER_BITS'(BUFFER_END);
    localparam logic [BUFFER_BITS-1:0] MAX_PIX32 = BUFFER_BITS'(((BUFFER_END + 1) >> 2) - 1);

    logic [1:0]             fsm_q, fsm_d;
    logic [2:0]             bitPat_q, bitPat_d;
    logic [2:0]             pixBit_q, pixBit_d;
    logic [1:0]             chan_q, chan_d;
    logic [BUFFER_BITS-1:0] pixel_q, pixel_d;
    logic [BUFFER_BITS-1:0] lastPix_q, lastPix_d;
    logic                   mode32_q, mode32_d;
    logic [GAP_BITS-1:0]    gapCnt_q, gapCnt_d;
    logic [BUFFER_BITS-1:0] addr_q, addr_d;
    logic                   stateOut_q, stateOut_d;
    logic                   frameDone_q, frameDone_d;
    logic                   busy_q, busy_d;

    logic [BUFFER_BITS-1:0] startLastPix;
    logic                   lastSlot;

    // In 32-bit mode the buffer holds four bytes per pixel, so fewer pixels fit.
    assign startLastPix = bus.regCtrl32bit
        ? ((bus.regLastPixel > MAX_PIX32) ? MAX_PIX32 : bus.regLastPixel)
        : ((bus.regLastPixel > MAX_PIX8)  ? MAX_PIX8  : bus.regLastPixel);

    assign lastSlot = (bitPat_q == 3'd7) && (pixBit_q == 3'd7) &&
                      (chan_q == 2'd2) && (pixel_q == lastPix_q);

    // Next-state and counter logic; indices fall back to zero outside TRANSMIT.
    always_comb begin
        fsm_d     = fsm_q;
        bitPat_d  = 3'd0;
        pixBit_d  = 3'd0;
        chan_d    = 2'd0;
        pixel_d   = '0;
        gapCnt_d  = '0;
        lastPix_d = lastPix_q;
        mode32_d  = mode32_q;
        case (fsm_q)
            IDLE: begin
                if (bus.regCtrlRun) begin
                    fsm_d     = TRANSMIT;
                    lastPix_d = startLastPix;
                    mode32_d  = bus.regCtrl32bit;
                end
            end
            TRANSMIT: begin
                if (!bus.regCtrlRun) begin
                    fsm_d = IDLE;
                end else if (lastSlot) begin
                    fsm_d = GAP;
                end else begin
                    bitPat_d = bitPat_q + 3'd1;
                    pixBit_d = pixBit_q;
                    chan_d   = chan_q;
                    pixel_d  = pixel_q;
                    if (bitPat_q == 3'd7) begin
                        pixBit_d = pixBit_q + 3'd1;
                        if (pixBit_q == 3'd7) begin
                            if (chan_q == 2'd2) begin
                                chan_d  = 2'd0;
                                pixel_d = pixel_q + BUFFER_BITS'(1);
                            end else begin
                                chan_d = chan_q + 2'd1;
                            end
                        end
                    end
                end
            end
            GAP: begin
                if (!bus.regCtrlRun) begin
                    fsm_d = IDLE;
                end else if (gapCnt_q == GAP_LAST) begin
                    if (bus.regCtrlLoop) begin
                        fsm_d     = TRANSMIT;
                        lastPix_d = startLastPix;
                        mode32_d  = bus.regCtrl32bit;
                    end else begin
                        fsm_d = DONE;
                    end
                end else begin
                    gapCnt_d = gapCnt_q + GAP_BITS'(1);
                end
            end
            DONE: begin
                if (!bus.regCtrlRun) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase

        addr_d      = mode32_d ? {pixel_d[BUFFER_BITS-3:0], chan_d} : pixel_d;
        stateOut_d  = (fsm_d == TRANSMIT) ? `ENUM_STATE_TRANSMIT : `ENUM_STATE_RESET;
        busy_d      = (fsm_d != IDLE);
        frameDone_d = (fsm_d == GAP) && (gapCnt_d == GAP_LAST);
    end

    // State and output registers, cleared asynchronously on reset.
    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            fsm_q       <= IDLE;
            bitPat_q    <= 3'd0;
            pixBit_q    <= 3'd0;
            chan_q      <= 2'd0;
            pixel_q     <= '0;
            lastPix_q   <= '0;
            mode32_q    <= 1'b0;
            gapCnt_q    <= '0;
            addr_q      <= '0;
            stateOut_q  <= `ENUM_STATE_RESET;
            frameDone_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            bitPat_q    <= bitPat_d;
            pixBit_q    <= pixBit_d;
            chan_q      <= chan_d;
            pixel_q     <= pixel_d;
            lastPix_q   <= lastPix_d;
            mode32_q    <= mode32_d;
            gapCnt_q    <= gapCnt_d;
            addr_q      <= addr_d;
            stateOut_q  <= stateOut_d;
            frameDone_q <= frameDone_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.state           = stateOut_q;
    assign bus.bitPatternIndex = bitPat_q;
    assign bus.pixelBitIndex   = pixBit_q;
    assign bus.channelIndex    = chan_q;
    assign bus.bufferAddr      = addr_q;
    assign bus.frameDone       = frameDone_q;
    assign bus.busy            = busy_q;

endmodule

// File: doc/anton_neopixel_sequencer.md
ANTON_NEOPIXEL_SEQUENCER -- requirements
Module: anton_neopixel_sequencer

Interface
REQ-001 Parameters SHALL be: BUFFER_END, default `BUFFER_END_DEFAULT, last valid buffer byte address; RESET_CYCLES, default 400, low-time cycles between frames (62.5 us at 6.4 MHz).
REQ-002 Derived width SHALL be BUFFER_BITS = `CLOG2(BUFFER_END+1).
REQ-003 Port clk6_4mhz  in  1  sole clock, all flops rising-edge.
REQ-004 Port rstn  in  1  reset, asynchronous, active-low.
REQ-005 Port regCtrlRun  in  1  start/keep streaming; low aborts.
REQ-006 Port regCtrlLoop  in  1  1 = restart frame after reset gap; 0 = single frame.
REQ-007 Port regCtrl32bit  in  1  1 = 4 bytes/pixel (4th unused); 0 = 1 byte/pixel.
REQ-008 Port regLastPixel  in  BUFFER_BITS  index of last pixel to send.
REQ-009 Port state  out  1  `ENUM_STATE_TRANSMIT while bits are driven, else `ENUM_STATE_RESET.
REQ-010 Port bitPatternIndex  out  3  slot 0-7 within one bit.
REQ-011 Port pixelBitIndex  out  3  bit 0-7 within one channel.
REQ-012 Port channelIndex  out  2  channel 0-2 (G, R, B).
REQ-013 Port bufferAddr  out  BUFFER_BITS  byte address of current pixelByte.
REQ-014 Port frameDone  out  1  one-cycle pulse at end of reset gap.
REQ-015 Port busy  out  1  high in TRANSMIT, GAP or DONE.

Function
REQ-016 FSM states SHALL be IDLE, TRANSMIT, GAP, DONE; all outputs registered.
REQ-017 IDLE -> TRANSMIT SHALL occur on the edge after regCtrlRun is sampled high; first TRANSMIT cycle has all indices 0, bufferAddr 0.
REQ-018 At frame start, lastPix SHALL latch min(regLastPixel, BUFFER_END) in 8-bit mode or min(regLastPixel, ((BUFFER_END+1)>>2)-1) in 32-bit mode; regCtrl32bit also latched; both held until next frame start.
REQ-019 In TRANSMIT, bitPatternIndex SHALL increment every cycle, wrapping 7 -> 0.
REQ-020 On bitPatternIndex wrap, pixelBitIndex SHALL increment, wrapping 7 -> 0.
REQ-021 On pixelBitIndex wrap, channelIndex SHALL increment 0 -> 1 -> 2 -> 0; value 3 never produced.
REQ-022 On channelIndex wrap 2 -> 0, pixel counter SHALL increment; each pixel occupies exactly 192 cycles.
REQ-023 bufferAddr SHALL equal pixel in 8-bit mode, {pixel, channelIndex} (pixel*4+channel) in 32-bit mode, updating in the same cycle as the indices.
REQ-024 On the last slot of channel 2 of pixel lastPix, next state SHALL be GAP, all indices and bufferAddr cleared to 0.
REQ-025 GAP SHALL last exactly RESET_CYCLES cycles with state = `ENUM_STATE_RESET; frameDone pulses on the last GAP cycle.
REQ-026 After GAP: regCtrlLoop=1 and regCtrlRun=1 -> TRANSMIT (new latch per REQ-018); regCtrlLoop=0 -> DONE.
REQ-027 DONE SHALL hold until regCtrlRun is sampled low, then IDLE; no retrigger while run stays high.
REQ-028 regCtrlRun sampled low in TRANSMIT or GAP SHALL force GAP-less return to IDLE next cycle, indices cleared, no frameDone.
REQ-029 Changes of regLastPixel, regCtrl32bit or regCtrlLoop mid-frame SHALL not affect the current frame (loop sampled only at GAP end).
REQ-030 regLastPixel = 0 SHALL yield a one-pixel (192-cycle) frame.

Reset
REQ-031 rstn low SHALL asynchronously force IDLE, state = `ENUM_STATE_RESET, all indices, bufferAddr, frameDone, busy = 0, GAP counter 0.
REQ-032 Release of rstn mid-frame SHALL restart from IDLE; no partial frame resumes.

Verification
REQ-033 8-bit, regLastPixel=2, loop=0, run=1 -> 576 TRANSMIT cycles, bufferAddr 0,1,2 each for 192 cycles, 400 GAP cycles, one frameDone, DONE until run low.
REQ-034 32-bit, BUFFER_END=15, regLastPixel=9 -> lastPix clamped to 3, bufferAddr sequence 0,1,2,4,5,6,8,9,10,12,13,14, 768 TRANSMIT cycles.
REQ-035 loop=1, regLastPixel=0 -> repeating 192 TRANSMIT + 400 GAP, frameDone every 592 cycles; regLastPixel changed mid-frame takes effect next frame only.
REQ-036 run dropped at TRANSMIT cycle 100 -> IDLE next cycle, all outputs 0, no frameDone.
REQ-037 rstn asserted mid-GAP, released 3 cycles later with run high -> immediate output clear, new frame starts at indices 0 after release.
REQ-038 Index check: every TRANSMIT cycle channelIndex < 3, bitPatternIndex steps by 1 mod 8, pixelBitIndex steps only on bitPatternIndex 7.
